// File: rtl/cache_op_done_ctrl_pkg.sv
// Shared types and default per-class latencies for the cache op completion controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RD_HIT  = 2'd0,
    OP_RD_MISS = 2'd1,
    OP_WR_HIT  = 2'd2,
    OP_WR_MISS = 2'd3
  } op_class_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } done_state_t;

  localparam int DEF_RD_HIT_CYCLES  = 2;
  localparam int DEF_RD_MISS_CYCLES = 3;
  localparam int DEF_WR_HIT_CYCLES  = 2;
  localparam int DEF_WR_MISS_CYCLES = 3;
  localparam int DEF_WB_CYCLES      = 2;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b; else m = m;
    if (c > m) m = c; else m = m;
    if (d > m) m = d; else m = m;
    return m;
  endfunction

endpackage

// File: rtl/cache_op_done_ctrl_latency_counter.sv
// Loadable down-counter with zero/one flags; load wins over decrement, decrement saturates at zero.
module latency_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             one
);

  logic [CNT_W-1:0] count_r;

  // Count register: load, saturating decrement, or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});
  assign one  = (count_r == CNT_W'(1'b1));

endmodule

// File: rtl/cache_op_done_ctrl.sv
// Cache op completion controller: classifies an accepted op, times its latency, pulses done.
// Optional dirty-victim write-back latency is enabled by defining CACHE_DIRTY_WB_EN.
module cache_op_done_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int RD_HIT_CYCLES  = DEF_RD_HIT_CYCLES,
  parameter int RD_MISS_CYCLES = DEF_RD_MISS_CYCLES,
  parameter int WR_HIT_CYCLES  = DEF_WR_HIT_CYCLES,
  parameter int WR_MISS_CYCLES = DEF_WR_MISS_CYCLES,
  parameter int WB_CYCLES      = DEF_WB_CYCLES
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      re,
  input  logic      we,
  input  logic      hit,
`ifdef CACHE_DIRTY_WB_EN
  input  logic      dirty,
`endif
  output logic      accept,
  output logic      busy,
  output logic      done,
  output op_class_t op_class,
  output logic      err
);

  localparam int MAX_LAT = max_of4(RD_HIT_CYCLES, RD_MISS_CYCLES, WR_HIT_CYCLES, WR_MISS_CYCLES)
                           + WB_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  if ((RD_HIT_CYCLES < 1) || (RD_MISS_CYCLES < 1) || (WR_HIT_CYCLES < 1) ||
      (WR_MISS_CYCLES < 1) || (WB_CYCLES < 1)) begin : g_bad_cfg
    $error("cache_op_done_ctrl: every *_CYCLES parameter must be >= 1");
  end

  done_state_t      state_r;
  op_class_t        op_class_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             ready_s;
  logic             conflict_s;
  logic             wb_s;
  logic             cnt_zero_s;
  logic             cnt_one_s;
  op_class_t        cls_s;
  logic [CNT_W-1:0] base_m1_s;
  logic [CNT_W-1:0] lat_m1_s;

  assign ready_s    = (state_r == S_IDLE) || (state_r == S_DONE);
  assign accept     = ready_s & (re ^ we);
  assign conflict_s = ready_s & re & we;
  assign cls_s      = op_class_t'({we, ~hit});

`ifdef CACHE_DIRTY_WB_EN
  assign wb_s = ~hit & dirty;
`else
  assign wb_s = 1'b0;
`endif

  // Class latency minus one, i.e. the counter preload value.
  always_comb begin
    base_m1_s = {CNT_W{1'b0}};
    case (cls_s)
      OP_RD_HIT:  base_m1_s = CNT_W'(RD_HIT_CYCLES - 1);
      OP_RD_MISS: base_m1_s = CNT_W'(RD_MISS_CYCLES - 1);
      OP_WR_HIT:  base_m1_s = CNT_W'(WR_HIT_CYCLES - 1);
      OP_WR_MISS: base_m1_s = CNT_W'(WR_MISS_CYCLES - 1);
      default:    base_m1_s = {CNT_W{1'b0}};
    endcase
  end

  assign lat_m1_s = wb_s ? (base_m1_s + CNT_W'(WB_CYCLES)) : base_m1_s;

  latency_counter #(
    .CNT_W(CNT_W)
  ) u_latency_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .dec      ((state_r == S_COUNT) & ~cnt_zero_s),
    .load_val (lat_m1_s),
    .zero     (cnt_zero_s),
    .one      (cnt_one_s)
  );

  // Completion FSM; a ready state with a fresh accept starts the next op without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      op_class_r <= OP_RD_HIT;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      err_r <= conflict_s;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_class_r <= cls_s;
            busy_r     <= 1'b1;
            if (lat_m1_s == {CNT_W{1'b0}}) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_COUNT;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        S_COUNT: begin
          busy_r <= 1'b1;
          // A zero count here is unreachable; finishing the op is the safe recovery.
          if (cnt_one_s || cnt_zero_s) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_COUNT;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign op_class = op_class_r;

endmodule

// File: tb/tb_cache_op_done_ctrl.sv
// Self-checking bench for cache_op_done_ctrl: directed scenarios plus randomized traffic vs a timeline model.
module tb_cache_op_done_ctrl;

  localparam int RD_HIT  = 2;
  localparam int RD_MISS = 3;
  localparam int WR_HIT  = 2;
  localparam int WR_MISS = 3;
  localparam int WB      = 2;
`ifdef CACHE_DIRTY_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       re;
  logic       we;
  logic       hit;
  logic       dirty;
  logic       accept;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] op_class;

  int checks = 0;
  int failures = 0;

  // Timeline model: an op accepted in cycle t with latency L completes in cycle t+L.
  int m_cyc;
  int m_done_at;
  int m_class;
  bit m_err;

  always #5 clk = ~clk;

  cache_op_done_ctrl #(
    .RD_HIT_CYCLES  (RD_HIT),
    .RD_MISS_CYCLES (RD_MISS),
    .WR_HIT_CYCLES  (WR_HIT),
    .WR_MISS_CYCLES (WR_MISS),
    .WB_CYCLES      (WB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .re       (re),
    .we       (we),
    .hit      (hit),
`ifdef CACHE_DIRTY_WB_EN
    .dirty    (dirty),
`endif
    .accept   (accept),
    .busy     (busy),
    .done     (done),
    .op_class (op_class),
    .err      (err)
  );

  function automatic int m_lat(input bit w, input bit h, input bit d);
    int l;
    l = w ? (h ? WR_HIT : WR_MISS) : (h ? RD_HIT : RD_MISS);
    l += (WB_EN && !h && d) ? WB : 0;
    return l;
  endfunction

  function automatic bit m_busy();
    return m_cyc <= m_done_at;
  endfunction

  function automatic bit m_ready();
    return (m_cyc > m_done_at) || (m_cyc == m_done_at);
  endfunction

  task automatic m_reset();
    m_cyc = 0; m_done_at = -1; m_class = 0; m_err = 1'b0;
  endtask

  task automatic m_edge(input bit r, input bit w, input bit h, input bit d);
    bit rdy;
    rdy = m_ready();
    m_err = rdy && r && w;
    if (rdy && (r ^ w)) begin
      m_done_at = m_cyc + m_lat(w, h, d);
      m_class = {30'd0, w, !h};
    end
    m_cyc++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; re = 1'b0; we = 1'b0; hit = 1'b0; dirty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", err); end
    checks++; if (op_class !== 2'd0) begin failures++; $display("FAIL rst_class got=%0d want=0", op_class); end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #3;
      checks++; if ({accept, busy, done, err} !== 4'b0000) begin
        failures++; $display("FAIL post_rst_idle got=%b want=0000", {accept, busy, done, err});
      end
    end
    next_cycle();
  endtask

  // One isolated op from idle: accept in cycle 0, busy 1..L, done only in L.
  task automatic test_single(input bit w, input bit h, input bit d, input int lat, input logic [1:0] cls);
    for (int c = 0; c <= lat + 1; c++) begin
      re = (c == 0) && !w; we = (c == 0) && w; hit = h; dirty = d;
      #3;
      checks++; if (accept !== (c == 0)) begin
        failures++; $display("FAIL single_accept w=%0d h=%0d c=%0d got=%b want=%b", w, h, c, accept, (c == 0));
      end
      checks++; if (busy !== (c >= 1 && c <= lat)) begin
        failures++; $display("FAIL single_busy w=%0d h=%0d c=%0d got=%b want=%b", w, h, c, busy, (c >= 1 && c <= lat));
      end
      checks++; if (done !== (c == lat)) begin
        failures++; $display("FAIL single_done w=%0d h=%0d c=%0d got=%b want=%b", w, h, c, done, (c == lat));
      end
      if (c >= 1) begin
        checks++; if (op_class !== cls) begin
          failures++; $display("FAIL single_class c=%0d got=%0d want=%0d", c, op_class, cls);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 8; c++) begin
      re = 1'b1; we = 1'b0; hit = 1'b1; dirty = 1'b0;
      #3;
      checks++; if (accept !== (c % 2 == 0)) begin
        failures++; $display("FAIL b2b_accept c=%0d got=%b want=%b", c, accept, (c % 2 == 0));
      end
      checks++; if (done !== (c >= 2 && c % 2 == 0)) begin
        failures++; $display("FAIL b2b_done c=%0d got=%b want=%b", c, done, (c >= 2 && c % 2 == 0));
      end
      checks++; if (busy !== (c >= 1)) begin
        failures++; $display("FAIL b2b_busy c=%0d got=%b want=%b", c, busy, (c >= 1));
      end
      next_cycle();
    end
    re = 1'b0;
    #3;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_last_done got=%b want=1", done); end
    repeat (3) next_cycle();
  endtask

  task automatic test_conflict();
    re = 1'b1; we = 1'b1; hit = 1'b1;
    #3;
    checks++; if (accept !== 1'b0) begin failures++; $display("FAIL conf_accept got=%b want=0", accept); end
    next_cycle();
    re = 1'b0; we = 1'b0;
    #3;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL conf_err got=%b want=1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL conf_busy got=%b want=0", busy); end
    next_cycle();
    test_single(1'b0, 1'b0, 1'b0, RD_MISS, 2'd1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL conf_err_clear got=%b want=0", err); end
  endtask

  task automatic test_reset_mid_op();
    re = 1'b1; we = 1'b0; hit = 1'b0; dirty = 1'b0;
    #3;
    checks++; if (accept !== 1'b1) begin failures++; $display("FAIL mid_accept got=%b want=1", accept); end
    next_cycle();
    re = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++; if ({busy, done, err} !== 3'b000) begin
      failures++; $display("FAIL mid_rst_out got=%b want=000", {busy, done, err});
    end
    checks++; if (op_class !== 2'd0) begin failures++; $display("FAIL mid_rst_class got=%0d want=0", op_class); end
    repeat (2) next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #3;
      checks++; if ({busy, done} !== 2'b00) begin
        failures++; $display("FAIL mid_no_done c=%0d got=%b want=00", c, {busy, done});
      end
      next_cycle();
    end
    test_single(1'b0, 1'b1, 1'b0, RD_HIT, 2'd0);
  endtask

  task automatic test_random();
    int sel;
    rst = 1'b0; re = 1'b0; we = 1'b0;
    next_cycle();
    rst = 1'b1;
    m_reset();
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      re = (sel < 4) || (sel == 7);
      we = (sel >= 4 && sel <= 7);
      hit = 1'($urandom_range(0, 1));
      dirty = 1'($urandom_range(0, 1));
      #3;
      checks++; if (accept !== (m_ready() && (re ^ we))) begin
        failures++; $display("FAIL rnd_accept cyc=%0d got=%b want=%b", m_cyc, accept, (m_ready() && (re ^ we)));
      end
      checks++; if (busy !== m_busy()) begin
        failures++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", m_cyc, busy, m_busy());
      end
      checks++; if (done !== (m_cyc == m_done_at)) begin
        failures++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", m_cyc, done, (m_cyc == m_done_at));
      end
      checks++; if (err !== m_err) begin
        failures++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", m_cyc, err, m_err);
      end
      checks++; if (op_class !== m_class[1:0]) begin
        failures++; $display("FAIL rnd_class cyc=%0d got=%0d want=%0d", m_cyc, op_class, m_class);
      end
      m_edge(re, we, hit, dirty);
      next_cycle();
    end
    re = 1'b0; we = 1'b0;
    repeat (8) next_cycle();
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 1'b1, 1'b0, RD_HIT, 2'd0);
    test_single(1'b1, 1'b0, 1'b0, WR_MISS, 2'd3);
    test_single(1'b1, 1'b1, 1'b0, WR_HIT, 2'd2);
    test_back_to_back();
    test_conflict();
`ifdef CACHE_DIRTY_WB_EN
    test_single(1'b0, 1'b0, 1'b1, RD_MISS + WB, 2'd1);
`endif
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
